// File: rtl/noc_pkg.sv
// Shared NoC definitions: flit layout, flit type encoding and router port indices.
package noc_pkg;

    localparam int FLIT_W    = 16;
    localparam int VALID_BIT = 15;
    localparam int TYPE_HI   = 14;
    localparam int TYPE_LO   = 13;

    typedef enum logic [1:0] {
        BODY   = 2'b00,
        HEAD   = 2'b01,
        TAIL   = 2'b10,
        SINGLE = 2'b11
    } flit_type_t;

    typedef logic [FLIT_W-1:0] flit_t;

    typedef enum logic [2:0] {
        N = 3'd0,
        S = 3'd1,
        E = 3'd2,
        W = 3'd3,
        L = 3'd4
    } port_idx_t;

    function automatic flit_type_t get_type(input flit_t f);
        return flit_type_t'(f[TYPE_HI:TYPE_LO]);
    endfunction

endpackage

// File: rtl/credit_counter.sv
// Saturating up/down slot counter starting full at DEPTH; flags a return that would exceed DEPTH.
module credit_counter #(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             dec,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             nonzero,
    output logic             overflow
);

    localparam logic [CNT_W-1:0] FULL = CNT_W'(DEPTH);

    logic [CNT_W-1:0] count_reg;
    logic [CNT_W-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        overflow   = 1'b0;
        if (dec && !inc) begin
            if (count_reg != '0) begin
                count_next = count_reg - 1'b1;
            end
        end else if (inc && !dec) begin
            // A return while already full means the neighbour sent a spurious credit.
            if (count_reg == FULL) begin
                overflow = 1'b1;
            end else begin
                count_next = count_reg + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_reg <= FULL;
        end else begin
            count_reg <= count_next;
        end
    end

    assign count   = count_reg;
    assign nonzero = (count_reg != '0);

endmodule

// File: rtl/credit_tx.sv
// Router output-port transmitter: credit-gated flit send onto the link with wormhole framing checks.
module credit_tx
    import noc_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [15:0]      flit_i,
    input  logic             flit_valid_i,
    output logic             flit_ready_o,
    output logic [15:0]      data_o,
    input  logic             incr_i,
    output logic [CNT_W-1:0] credits_o,
    output logic             lock_o,
    output logic             err_o
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t     state_reg;
    state_t     state_next;
    flit_t      data_reg;
    flit_t      data_next;
    logic       err_reg;
    logic       err_next;
    logic       send;
    logic       has_credit;
    logic       overflow;
    flit_type_t ftype;
    logic       unused_valid_bit;

    // Validity on input comes from the handshake only; bit 15 is rewritten on send.
    assign unused_valid_bit = flit_i[VALID_BIT];

    assign flit_ready_o = has_credit;
    assign send         = flit_valid_i && has_credit;
    assign ftype        = get_type(flit_i);

    credit_counter #(
        .DEPTH (DEPTH)
    ) u_credit_counter (
        .clk      (clk),
        .rst      (rst),
        .dec      (send),
        .inc      (incr_i),
        .count    (credits_o),
        .nonzero  (has_credit),
        .overflow (overflow)
    );

    always_comb begin
        state_next = state_reg;
        data_next  = '0;
        err_next   = err_reg | overflow;
        if (send) begin
            data_next = {1'b1, flit_i[VALID_BIT-1:0]};
            unique case (state_reg)
                IDLE: begin
                    if (ftype == HEAD) begin
                        state_next = ACTIVE;
                    end else if (ftype == BODY || ftype == TAIL) begin
                        err_next = 1'b1;
                    end
                end
                ACTIVE: begin
                    if (ftype == TAIL) begin
                        state_next = IDLE;
                    end else if (ftype == HEAD || ftype == SINGLE) begin
                        err_next = 1'b1;
                    end
                end
                default: state_next = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg <= IDLE;
            data_reg  <= '0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            data_reg  <= data_next;
            err_reg   <= err_next;
        end
    end

    assign data_o = data_reg;
    assign lock_o = (state_reg == ACTIVE);
    assign err_o  = err_reg;

endmodule

// File: tb/tb_credit_tx.sv
// Directed bench for credit_tx (DEPTH=4): credits, link timing, framing and reset behaviour.
module tb_credit_tx;

    logic        clk;
    logic        rst;
    logic [15:0] flit_i;
    logic        flit_valid_i;
    logic        flit_ready_o;
    logic [15:0] data_o;
    logic        incr_i;
    logic [2:0]  credits_o;
    logic        lock_o;
    logic        err_o;

    int n_vec;
    int n_fail;

    credit_tx #(.DEPTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .flit_i       (flit_i),
        .flit_valid_i (flit_valid_i),
        .flit_ready_o (flit_ready_o),
        .data_o       (data_o),
        .incr_i       (incr_i),
        .credits_o    (credits_o),
        .lock_o       (lock_o),
        .err_o        (err_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
        $display("vec %0d %s: observed %0h expected %0h", n_vec, tag, obs, exp);
    endtask

    task automatic send(input logic [15:0] f);
        flit_i       = f;
        flit_valid_i = 1'b1;
        step();
        flit_valid_i = 1'b0;
    endtask

    task automatic pulse_incr();
        incr_i = 1'b1;
        step();
        incr_i = 1'b0;
    endtask

    initial begin
        n_vec        = 0;
        n_fail       = 0;
        rst          = 1'b1;
        flit_i       = 16'h0000;
        flit_valid_i = 1'b0;
        incr_i       = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset state
        check("rst_credits", credits_o, 4);
        check("rst_data", data_o, 16'h0000);
        check("rst_ready", flit_ready_o, 1);
        check("rst_lock", lock_o, 0);
        check("rst_err", err_o, 0);

        // Credit exhaustion with back-to-back singles
        send(16'h6001);
        check("ex1_data", data_o, 16'hE001);
        check("ex1_credits", credits_o, 3);
        send(16'h6002);
        check("ex2_data", data_o, 16'hE002);
        send(16'h6003);
        check("ex3_data", data_o, 16'hE003);
        send(16'h6004);
        check("ex4_data", data_o, 16'hE004);
        check("ex4_credits", credits_o, 0);
        check("ex4_ready", flit_ready_o, 0);
        send(16'h6005);
        check("ex5_held_data", data_o, 16'h0000);
        check("ex5_held_credits", credits_o, 0);
        flit_valid_i = 1'b1;
        incr_i       = 1'b1;
        step();
        incr_i = 1'b0;
        check("retry_data_idle", data_o, 16'h0000);
        check("retry_credits", credits_o, 1);
        check("retry_ready", flit_ready_o, 1);
        step();
        flit_valid_i = 1'b0;
        check("retry_data", data_o, 16'hE005);
        check("retry_credits_after", credits_o, 0);
        step();
        check("idle_word", data_o, 16'h0000);

        // Simultaneous send and credit return at credits=2
        pulse_incr();
        pulse_incr();
        check("pre_sim_credits", credits_o, 2);
        incr_i = 1'b1;
        send(16'h6006);
        incr_i = 1'b0;
        check("sim_credits", credits_o, 2);
        check("sim_data", data_o, 16'hE006);
        pulse_incr();
        pulse_incr();
        check("refill_credits", credits_o, 4);
        check("refill_err", err_o, 0);

        // Wormhole packet
        send(16'h2010);
        check("wh_head_data", data_o, 16'hA010);
        check("wh_head_lock", lock_o, 1);
        send(16'h0011);
        check("wh_b1_data", data_o, 16'h8011);
        check("wh_b1_lock", lock_o, 1);
        send(16'h0012);
        check("wh_b2_data", data_o, 16'h8012);
        send(16'h4013);
        check("wh_tail_data", data_o, 16'hC013);
        check("wh_tail_lock", lock_o, 0);
        check("wh_err", err_o, 0);
        check("wh_credits", credits_o, 0);
        for (int i = 0; i < 4; i++) pulse_incr();
        check("wh_refill", credits_o, 4);

        // Tail without head
        send(16'h4020);
        check("orphan_tail_data", data_o, 16'hC020);
        check("orphan_tail_err", err_o, 1);
        check("orphan_tail_lock", lock_o, 0);
        step();
        check("err_sticky", err_o, 1);

        // Head while a packet is active (from a clean reset)
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst2_err", err_o, 0);
        send(16'h2030);
        check("hh_first_lock", lock_o, 1);
        check("hh_first_err", err_o, 0);
        send(16'h2031);
        check("hh_second_data", data_o, 16'hA031);
        check("hh_second_err", err_o, 1);
        check("hh_second_lock", lock_o, 1);
        send(16'h4032);
        check("hh_tail_lock", lock_o, 0);

        // Overflow
        rst = 1'b1;
        step();
        rst = 1'b0;
        pulse_incr();
        check("ovf_credits", credits_o, 4);
        check("ovf_err", err_o, 1);

        // Reset mid-packet, with a flit offered in the reset cycle
        send(16'h2040);
        check("mid_lock", lock_o, 1);
        check("mid_credits", credits_o, 3);
        rst          = 1'b1;
        flit_i       = 16'h0041;
        flit_valid_i = 1'b1;
        step();
        rst          = 1'b0;
        flit_valid_i = 1'b0;
        check("mid_rst_lock", lock_o, 0);
        check("mid_rst_credits", credits_o, 4);
        check("mid_rst_data", data_o, 16'h0000);
        check("mid_rst_err", err_o, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
